// File: rtl/glb_stream_pack.sv
// Packetizer ahead of the GLB stream sink: buffers one sparse transfer
// up to DONE, then emits header + length-prefixed sub-streams.
module glb_stream_pack #(
  parameter int DATA_DEPTH = 256,
  parameter int SEG_DEPTH  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        seg_mode,
  input  logic [16:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [16:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] tx_count,
  output logic        overflow
);

  localparam int AD = $clog2(DATA_DEPTH);
  localparam int AS = $clog2(SEG_DEPTH);
  localparam int DW = AD + 1;
  localparam int SW = AS + 1;
  localparam int PW = (DW > SW) ? DW : SW;

  typedef enum logic [2:0] {
    COLLECT,
    HDR,
    SEG_LEN,
    SEG_DATA,
    CRD_LEN,
    CRD_DATA
  } state_t;

  state_t state_q, state_d;

  logic [15:0]   dmem [DATA_DEPTH];
  logic [DW-1:0] smem [SEG_DEPTH];

  logic [DW-1:0] data_cnt;
  logic [SW-1:0] seg_cnt;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] seg_last, crd_last;
  logic          mode_r;
  logic          start_q;
  logic          fin;

  logic accept, is_tok, is_done, is_stop;
  logic d_full, s_full;
  logic wr_data, wr_seg, drop;
  logic hs;

  assign in_ready = (state_q == COLLECT) & ~start_q;
  assign accept   = in_valid & in_ready;
  assign is_tok   = in_data[16];
  assign is_done  = is_tok & in_data[8];
  assign is_stop  = is_tok & ~in_data[8];
  assign d_full   = (data_cnt == DW'(DATA_DEPTH));
  assign s_full   = (seg_cnt == SW'(SEG_DEPTH));
  assign wr_data  = accept & ~is_tok & ~d_full;
  assign wr_seg   = accept & is_stop & mode_r & ~s_full;
  assign drop     = accept & ((~is_tok & d_full) |
                              (is_stop & mode_r & s_full));
  assign hs       = out_valid & out_ready;
  assign seg_last = PW'(seg_cnt) - PW'(1);
  assign crd_last = PW'(data_cnt) - PW'(1);

  always_comb begin
    state_d = state_q;
    rptr_d  = rptr_q;
    fin     = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (accept && is_done) state_d = HDR;
      end
      HDR: begin
        if (hs) state_d = mode_r ? SEG_LEN : CRD_LEN;
      end
      SEG_LEN: begin
        if (hs) begin
          rptr_d  = '0;
          state_d = (seg_cnt == '0) ? CRD_LEN : SEG_DATA;
        end
      end
      SEG_DATA: begin
        if (hs) begin
          if (rptr_q == seg_last) state_d = CRD_LEN;
          else rptr_d = rptr_q + PW'(1);
        end
      end
      CRD_LEN: begin
        if (hs) begin
          rptr_d = '0;
          if (data_cnt == '0) fin = 1'b1;
          else state_d = CRD_DATA;
        end
      end
      CRD_DATA: begin
        if (hs) begin
          if (rptr_q == crd_last) fin = 1'b1;
          else rptr_d = rptr_q + PW'(1);
        end
      end
      default: state_d = COLLECT;
    endcase
    if (fin) state_d = COLLECT;
  end

  always_comb begin
    out_data = '0;
    unique case (state_q)
      HDR:      out_data = {1'b0, tx_count};
      SEG_LEN:  out_data = 17'(seg_cnt);
      SEG_DATA: out_data = 17'(smem[rptr_q[AS-1:0]]);
      CRD_LEN:  out_data = 17'(data_cnt);
      CRD_DATA: out_data = {1'b0, dmem[rptr_q[AD-1:0]]};
      default:  out_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      rptr_q    <= '0;
      out_valid <= 1'b0;
      data_cnt  <= '0;
      seg_cnt   <= '0;
      mode_r    <= 1'b0;
      start_q   <= 1'b1;
      tx_count  <= '0;
      overflow  <= 1'b0;
    end else if (flush) begin
      state_q   <= COLLECT;
      rptr_q    <= '0;
      out_valid <= 1'b0;
      data_cnt  <= '0;
      seg_cnt   <= '0;
      mode_r    <= 1'b0;
      start_q   <= 1'b1;
      tx_count  <= '0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rptr_q    <= rptr_d;
      out_valid <= (state_d != COLLECT);
      if (wr_data) data_cnt <= data_cnt + DW'(1);
      if (wr_seg) seg_cnt <= seg_cnt + SW'(1);
      if (drop) overflow <= 1'b1;
      // COLLECT entry: seg[0] holds the implicit leading 0
      if (start_q || fin) begin
        start_q <= 1'b0;
        mode_r  <= seg_mode;
        seg_cnt <= seg_mode ? SW'(1) : '0;
        if (fin) begin
          tx_count <= tx_count + 16'd1;
          data_cnt <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_data) dmem[data_cnt[AD-1:0]] <= in_data[15:0];
    if (wr_seg) smem[seg_cnt[AS-1:0]] <= data_cnt;
    else if (start_q || fin) smem[0] <= '0;
  end

endmodule

// File: doc/glb_stream_pack.md
Name: glb_stream_pack

Overview:
- Synthesizable packetizer directly upstream of the GLB stream sink.
- Consumes a fabric sparse stream in which bit 16 marks a control token, and buffers one transfer up to its DONE token.
- Emits the transfer as the length-prefixed block format the GLB read side expects:
  - header word, then
  - seg_mode=1: segment sub-stream followed by coordinate sub-stream;
  - seg_mode=0: a single value sub-stream.
  - Each sub-stream is a length word followed by that many data words.

Parameters:
- DATA_DEPTH, 256, capacity of the coordinate/value buffer in words (power of 2).
- SEG_DEPTH, 64, capacity of the segment buffer in words (power of 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of all state except config; same effect as reset
- seg_mode  in  1  1 = emit segment and coordinate sub-streams; 0 = emit a single value sub-stream; sampled at start of each transfer
- in_data  in  17  bit16 = token flag, [15:0] = payload
- in_valid  in  1  upstream valid
- in_ready  out  1  upstream ready
- out_data  out  17  packed stream word to the GLB
- out_valid  out  1  downstream valid
- out_ready  in  1  downstream ready
- tx_count  out  16  number of completed transfers
- overflow  out  1  sticky; a word was dropped because a buffer was full

Behaviour:
- Reset/flush values: all outputs 0, state COLLECT, both buffers empty, tx_count=0, overflow=0.
  - in_ready rises the first cycle after rst_n deasserts or flush drops.
- Input token decode, on an accepted word (in_valid & in_ready):
  - bit16=0: data word, written to the data buffer at data_cnt, data_cnt++.
  - bit16=1 and payload[8]=1: DONE token.
  - bit16=1 and payload[8]=0: STOP token.
- State COLLECT:
  - in_ready=1, out_valid=0.
  - On entry, latch seg_mode into mode_r. If mode_r=1, write seg[0]=0 and set seg_cnt=1.
  - STOP with mode_r=1: append data_cnt to the segment buffer. STOP with mode_r=0: discarded.
  - DONE: next state HDR; in_ready=0 from the following cycle.
- Full handling, in COLLECT:
  - Data word arriving with data_cnt==DATA_DEPTH: word accepted and dropped, overflow=1.
  - STOP arriving with seg_cnt==SEG_DEPTH: token accepted and dropped, overflow=1.
  - Never back-pressure in COLLECT; this prevents deadlock.
- Emit states: in_ready=0 throughout.
  - out_valid is registered; out_data is stable while out_valid=1 and out_ready=0.
  - Each state advances only on an out_valid & out_ready handshake.
  - HDR: out_data={1'b0, tx_count}.
  - mode_r=1: HDR -> SEG_LEN ({1'b0, seg_cnt}) -> SEG_DATA (seg[0..seg_cnt-1], each zero-extended) -> CRD_LEN ({1'b0, data_cnt}) -> CRD_DATA (buf[0..data_cnt-1]).
  - mode_r=0: HDR -> CRD_LEN -> CRD_DATA.
  - A length of 0 skips the following data state; the next word is the next length word, or the transfer ends.
  - After the final handshake: tx_count++ (wraps at 16 bits), counters cleared, back to COLLECT.
    - in_ready=1 on the next cycle.
    - No dead cycle is required between consecutive out words.
- Latency:
  - DONE accepted in cycle N -> header presented with out_valid=1 in cycle N+1.
  - Minimum transfer emission is 1 + sub-streams + words cycles at out_ready=1.
- Buffers: single-port arrays, reads combinationally indexed by a read pointer. Width of length fields is clog2(depth)+1, zero-extended to 17 bits.
- Reset mid-emit: output aborts immediately; out_valid=0 asynchronously; buffered data discarded. Flush behaves the same at the next edge.
- seg_mode changes mid-transfer have no effect until the next COLLECT entry.
- overflow clears only on reset or flush.

Test Plan:
- seg_mode=0; in: 0x0005, 0x0007, 0x0009, DONE (0x10100); out_ready=1 -> out 0x00000, 0x00003, 0x00005, 0x00007, 0x00009; tx_count=1; in_ready high the cycle after the last word.
- seg_mode=1; in: 3, 5, STOP(0x10000), 8, STOP, DONE -> out hdr 0, seg_len 3, seg 0, 2, 3, crd_len 3, crd 3, 5, 8.
- Empty transfer, seg_mode=0; DONE only -> out 0x00000, 0x00000, then COLLECT; tx_count=1. seg_mode=1 with DONE only -> hdr, 1, 0, 0.
- Random out_ready stalls (~50%) on the case-2 stream -> identical word sequence; out_data held constant across every stall cycle.
- DATA_DEPTH=4; send 6 data words then DONE -> overflow=1; crd_len 4 with the first 4 values only.
- Assert rst_n low while in SEG_DATA -> out_valid drops immediately; after release, a fresh case-1 transfer emits header 0x00000.
